// File: rtl/memory_access_unit.sv
// Memory stage: forwards ALU results with zero latency, or runs one load/store
// through a valid/ready request port and an in-order response port.
module memory_access_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   ALU_result_execute,
  input  logic [DATA_WIDTH-1:0]   store_data_execute,
  input  logic                    memRead_execute,
  input  logic                    memWrite_execute,
  input  logic [2:0]              funct3_execute,
  input  logic                    opwrite_execute,
  input  logic                    opsel_execute,
  input  logic [4:0]              opReg_execute,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDRESS_BITS-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [3:0]              mem_req_byte_en,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic [DATA_WIDTH-1:0]   ALU_result_memory,
  output logic [DATA_WIDTH-1:0]   load_data_memory,
  output logic                    opwrite_memory,
  output logic                    opsel_memory,
  output logic [4:0]              opReg_memory,
  output logic                    stall_memory,
  output logic                    misaligned_memory
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t                  state, state_next;
  logic                    capture_en;
  logic [DATA_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_data;
  logic [2:0]              cap_funct3;
  logic                    cap_write;
  logic                    cap_opwrite;
  logic                    cap_opsel;
  logic [4:0]              cap_opReg;

  logic                    misaligned_in;
  logic [DATA_WIDTH-1:0]   resp_shifted;
  logic [DATA_WIDTH-1:0]   load_word;
  logic [DATA_WIDTH-1:0]   wdata_word;
  logic [3:0]              byte_en_word;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cap_addr    <= '0;
      cap_data    <= '0;
      cap_funct3  <= '0;
      cap_write   <= 1'b0;
      cap_opwrite <= 1'b0;
      cap_opsel   <= 1'b0;
      cap_opReg   <= '0;
    end else begin
      state <= state_next;
      if (capture_en) begin
        cap_addr    <= ALU_result_execute;
        cap_data    <= store_data_execute;
        cap_funct3  <= funct3_execute;
        cap_write   <= memWrite_execute;
        cap_opwrite <= opwrite_execute;
        cap_opsel   <= opsel_execute;
        cap_opReg   <= opReg_execute;
      end
    end
  end

  always_comb begin
    misaligned_in = 1'b0;
    case (funct3_execute[1:0])
      2'b01:   misaligned_in = ALU_result_execute[0];
      2'b10:   misaligned_in = |ALU_result_execute[1:0];
      default: misaligned_in = 1'b0;
    endcase
  end

  // Request fields come only from captured registers, so they hold steady while ready is low.
  always_comb begin
    wdata_word   = cap_data;
    byte_en_word = 4'b1111;
    case (cap_funct3[1:0])
      2'b00: begin
        wdata_word   = {(DATA_WIDTH/8){cap_data[7:0]}};
        byte_en_word = 4'b0001 << cap_addr[1:0];
      end
      2'b01: begin
        wdata_word   = {(DATA_WIDTH/16){cap_data[15:0]}};
        byte_en_word = 4'b0011 << cap_addr[1:0];
      end
      default: begin
        wdata_word   = cap_data;
        byte_en_word = 4'b1111;
      end
    endcase
  end

  assign resp_shifted = mem_resp_data >> {cap_addr[1:0], 3'b000};

  always_comb begin
    load_word = mem_resp_data;
    case (cap_funct3)
      3'b000:  load_word = {{(DATA_WIDTH-8){resp_shifted[7]}}, resp_shifted[7:0]};
      3'b001:  load_word = {{(DATA_WIDTH-16){resp_shifted[15]}}, resp_shifted[15:0]};
      3'b100:  load_word = {{(DATA_WIDTH-8){1'b0}}, resp_shifted[7:0]};
      3'b101:  load_word = {{(DATA_WIDTH-16){1'b0}}, resp_shifted[15:0]};
      default: load_word = mem_resp_data;
    endcase
  end

  always_comb begin
    state_next        = state;
    capture_en        = 1'b0;
    mem_req_valid     = 1'b0;
    mem_req_write     = cap_write;
    mem_req_addr      = cap_addr[ADDRESS_BITS+1:2];
    mem_req_wdata     = wdata_word;
    mem_req_byte_en   = byte_en_word;
    ALU_result_memory = cap_addr;
    load_data_memory  = '0;
    opwrite_memory    = 1'b0;
    opsel_memory      = cap_opsel;
    opReg_memory      = cap_opReg;
    stall_memory      = 1'b0;
    misaligned_memory = 1'b0;

    if (reset) begin
      // Reset overrides the current state so no request or stall leaks out this cycle.
      state_next        = IDLE;
      ALU_result_memory = ALU_result_execute;
      opsel_memory      = opsel_execute;
      opReg_memory      = opReg_execute;
    end else begin
      case (state)
        IDLE: begin
          ALU_result_memory = ALU_result_execute;
          opsel_memory      = opsel_execute;
          opReg_memory      = opReg_execute;
          if (memRead_execute || memWrite_execute) begin
            if (misaligned_in) begin
              misaligned_memory = 1'b1;
            end else begin
              capture_en   = 1'b1;
              stall_memory = 1'b1;
              state_next   = REQ;
            end
          end else begin
            opwrite_memory = opwrite_execute;
          end
        end
        REQ: begin
          mem_req_valid = 1'b1;
          stall_memory  = 1'b1;
          if (mem_req_ready) begin
            if (cap_write) begin
              stall_memory   = 1'b0;
              opwrite_memory = cap_opwrite;
              state_next     = IDLE;
            end else begin
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          stall_memory = 1'b1;
          if (mem_resp_valid) begin
            load_data_memory = load_word;
            opwrite_memory   = cap_opwrite;
            stall_memory     = 1'b0;
            state_next       = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: table of single operations with a request and
// completion scoreboard, plus hand-written reset sequences.
module tb_memory_access_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ALU_result_execute, store_data_execute;
  logic        memRead_execute, memWrite_execute;
  logic [2:0]  funct3_execute;
  logic        opwrite_execute, opsel_execute;
  logic [4:0]  opReg_execute;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [19:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_byte_en;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] ALU_result_memory, load_data_memory;
  logic        opwrite_memory, opsel_memory;
  logic [4:0]  opReg_memory;
  logic        stall_memory, misaligned_memory;

  memory_access_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
    .clock(clock), .reset(reset),
    .ALU_result_execute(ALU_result_execute), .store_data_execute(store_data_execute),
    .memRead_execute(memRead_execute), .memWrite_execute(memWrite_execute),
    .funct3_execute(funct3_execute), .opwrite_execute(opwrite_execute),
    .opsel_execute(opsel_execute), .opReg_execute(opReg_execute),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_byte_en(mem_req_byte_en),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ALU_result_memory(ALU_result_memory), .load_data_memory(load_data_memory),
    .opwrite_memory(opwrite_memory), .opsel_memory(opsel_memory),
    .opReg_memory(opReg_memory), .stall_memory(stall_memory),
    .misaligned_memory(misaligned_memory)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, data, resp;
    int unsigned rdy_dly, rsp_dly;
    logic        opw, ops;
    logic [4:0]  opr;
    logic        exp_mis;
    logic [19:0] exp_maddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;
  } vec_t;

  typedef struct {
    logic        write;
    logic [19:0] maddr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic [31:0] alu, load;
    logic        opw, ops;
    logic [4:0]  opr;
    int unsigned lat;
  } cmp_exp_t;

  vec_t     vecs[$];
  req_exp_t req_q[$];
  cmp_exp_t cmp_q[$];
  int       n_vec = 0;
  int       n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] resp, input int unsigned rdy,
                              input int unsigned rsp, input logic mis,
                              input logic [19:0] maddr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.data = data; v.resp = resp;
    v.rdy_dly = rdy; v.rsp_dly = rsp; v.opw = 1'b1; v.ops = addr[2];
    v.opr = addr[4:0] ^ 5'h1b; v.exp_mis = mis; v.exp_maddr = maddr; v.exp_be = be;
    v.exp_wdata = wd; v.exp_load = ld;
    return v;
  endfunction

  task automatic idle_inputs();
    ALU_result_execute = $urandom;
    store_data_execute = $urandom;
    memRead_execute    = 1'b0;
    memWrite_execute   = 1'b0;
    funct3_execute     = 3'($urandom);
    opwrite_execute    = 1'b0;
    opsel_execute      = 1'b0;
    opReg_execute      = 5'($urandom);
  endtask

  task automatic complete_op(input int unsigned cyc);
    cmp_exp_t c;
    if (cmp_q.size() == 0) begin
      n_vec++; n_mis++;
      $display("FAIL scoreboard: completion with empty queue got 1 expected 0");
      return;
    end
    c = cmp_q.pop_front();
    chk("done_stall", stall_memory, 1'b0);
    chk("done_alu", ALU_result_memory, c.alu);
    chk("done_load", load_data_memory, c.load);
    chk("done_opwrite", opwrite_memory, c.opw);
    chk("done_opsel", opsel_memory, c.ops);
    chk("done_opreg", opReg_memory, c.opr);
    chk("latency", cyc, c.lat);
  endtask

  task automatic run_vec(input vec_t v);
    req_exp_t    r;
    cmp_exp_t    c;
    int unsigned wcnt;
    bit          in_wait, done;
    @(posedge clock); #1;
    ALU_result_execute = v.addr; store_data_execute = v.data;
    memRead_execute = v.rd; memWrite_execute = v.wr; funct3_execute = v.f3;
    opwrite_execute = v.opw; opsel_execute = v.ops; opReg_execute = v.opr;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clock);
    if (!(v.rd || v.wr)) begin
      chk("alu_result", ALU_result_memory, v.addr);
      chk("alu_opwrite", opwrite_memory, v.opw);
      chk("alu_opreg", opReg_memory, v.opr);
      chk("alu_stall", stall_memory, 1'b0);
      chk("alu_valid", mem_req_valid, 1'b0);
      chk("alu_load", load_data_memory, 32'h0);
      return;
    end
    if (v.exp_mis) begin
      chk("mis_pulse", misaligned_memory, 1'b1);
      chk("mis_valid", mem_req_valid, 1'b0);
      chk("mis_opwrite", opwrite_memory, 1'b0);
      chk("mis_stall", stall_memory, 1'b0);
      @(posedge clock); #1; idle_inputs();
      @(negedge clock);
      chk("mis_clear", misaligned_memory, 1'b0);
      chk("mis_no_req", mem_req_valid, 1'b0);
      return;
    end
    chk("issue_stall", stall_memory, 1'b1);
    chk("issue_opwrite", opwrite_memory, 1'b0);
    chk("issue_valid", mem_req_valid, 1'b0);
    r.write = v.wr; r.maddr = v.exp_maddr; r.be = v.exp_be; r.wdata = v.exp_wdata;
    req_q.push_back(r);
    c.alu = v.addr; c.load = v.wr ? 32'h0 : v.exp_load; c.opw = v.opw; c.ops = v.ops; c.opr = v.opr;
    c.lat = v.wr ? 2 + v.rdy_dly : 3 + v.rdy_dly + v.rsp_dly;
    cmp_q.push_back(c);
    wcnt = 0; in_wait = 0; done = 0;
    for (int unsigned cyc = 2; cyc < 30 && !done; cyc++) begin
      @(posedge clock); #1;
      idle_inputs();
      mem_req_ready  = !in_wait && (wcnt >= v.rdy_dly);
      mem_resp_valid = in_wait && (wcnt >= v.rsp_dly);
      mem_resp_data  = mem_resp_valid ? v.resp : $urandom;
      @(negedge clock);
      if (!in_wait) begin
        chk("req_valid", mem_req_valid, 1'b1);
        r = req_q[0];
        chk("req_write", mem_req_write, r.write);
        chk("req_addr", mem_req_addr, r.maddr);
        chk("req_byte_en", mem_req_byte_en, r.be);
        if (r.write) chk("req_wdata", mem_req_wdata, r.wdata);
        if (mem_req_ready) begin
          void'(req_q.pop_front());
          if (r.write) begin
            complete_op(cyc);
            done = 1;
          end else begin
            chk("hs_stall", stall_memory, 1'b1);
            chk("hs_opwrite", opwrite_memory, 1'b0);
            in_wait = 1; wcnt = 0;
          end
        end else begin
          chk("req_stall", stall_memory, 1'b1);
          chk("req_opwrite", opwrite_memory, 1'b0);
          wcnt++;
        end
      end else begin
        chk("wait_valid", mem_req_valid, 1'b0);
        if (mem_resp_valid) begin
          complete_op(cyc);
          done = 1;
        end else begin
          chk("wait_stall", stall_memory, 1'b1);
          chk("wait_opwrite", opwrite_memory, 1'b0);
          wcnt++;
        end
      end
    end
    if (!done) begin
      n_vec++; n_mis++;
      $display("FAIL timeout: op at addr %h got no completion expected completion", v.addr);
      req_q.delete(); cmp_q.delete();
    end
    @(posedge clock); #1;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs.push_back(mk(0,0,3'b000,32'h40,0,0,0,0,0,0,0,0,0));
    vecs[0].opr = 5'd5;
    vecs.push_back(mk(0,1,3'b010,32'h104,32'hDEADBEEF,0,0,0,0,20'h41,4'b1111,32'hDEADBEEF,0));
    vecs.push_back(mk(1,0,3'b000,32'h203,0,32'h80FF0000,0,0,0,20'h80,4'b1000,0,32'hFFFFFF80));
    vecs.push_back(mk(1,0,3'b100,32'h203,0,32'h80FF0000,0,0,0,20'h80,4'b1000,0,32'h00000080));
    vecs.push_back(mk(0,1,3'b001,32'h102,32'h0000BEEF,0,4,0,0,20'h40,4'b1100,32'hBEEFBEEF,0));
    vecs.push_back(mk(1,0,3'b010,32'h101,0,0,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,3'b001,32'h102,0,32'h80011234,0,2,0,20'h40,4'b1100,0,32'hFFFF8001));
    vecs.push_back(mk(1,0,3'b101,32'h100,0,32'h80019234,0,0,0,20'h40,4'b0011,0,32'h00009234));
    vecs.push_back(mk(1,0,3'b010,32'h208,0,32'h12345678,1,0,0,20'h82,4'b1111,0,32'h12345678));
    vecs.push_back(mk(0,1,3'b000,32'h001,32'h000000A5,0,0,0,0,20'h0,4'b0010,32'hA5A5A5A5,0));
    vecs.push_back(mk(1,0,3'b001,32'h103,0,0,0,0,1,0,0,0,0));
    vecs.push_back(mk(0,1,3'b010,32'h106,0,0,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,1,3'b010,32'h010,32'h11223344,0,0,0,0,20'h4,4'b1111,32'h11223344,0));
    vecs.push_back(mk(1,0,3'b000,32'h000,0,32'h0000007F,0,0,0,20'h0,4'b0001,0,32'h0000007F));
    vecs.push_back(mk(0,1,3'b001,32'h001,32'h1234,0,0,0,1,0,0,0,0));
    vecs.push_back(mk(1,0,3'b101,32'h002,0,32'hFEDC0000,0,1,0,20'h0,4'b1100,0,32'h0000FEDC));
    vecs.push_back(mk(0,0,3'b000,32'h12345678,0,0,0,0,0,0,0,0,0));

    // Reset with an aligned store and opwrite presented: nothing may leak out.
    reset = 1'b1; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;
    ALU_result_execute = 32'h100; store_data_execute = 32'h55; memRead_execute = 1'b0;
    memWrite_execute = 1'b1; funct3_execute = 3'b010; opwrite_execute = 1'b1;
    opsel_execute = 1'b1; opReg_execute = 5'd9;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rst_valid", mem_req_valid, 1'b0);
      chk("rst_stall", stall_memory, 1'b0);
      chk("rst_mis", misaligned_memory, 1'b0);
      chk("rst_opwrite", opwrite_memory, 1'b0);
      chk("rst_alu_pass", ALU_result_memory, 32'h100);
    end
    @(posedge clock); #1;
    reset = 1'b0; mem_req_ready = 1'b0; idle_inputs();
    @(negedge clock);
    chk("post_rst_valid", mem_req_valid, 1'b0);
    chk("post_rst_stall", stall_memory, 1'b0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_vec(v);
    end

    // Reset while a load sits in WAIT; a late response must be dropped.
    @(posedge clock); #1;
    ALU_result_execute = 32'h300; memRead_execute = 1'b1; funct3_execute = 3'b010;
    opwrite_execute = 1'b1; opReg_execute = 5'd7;
    @(posedge clock); #1; idle_inputs(); mem_req_ready = 1'b1;
    @(negedge clock);
    chk("r34_req_valid", mem_req_valid, 1'b1);
    @(posedge clock); #1; mem_req_ready = 1'b0;
    @(negedge clock);
    chk("r34_wait_stall", stall_memory, 1'b1);
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    chk("r34_rst_stall", stall_memory, 1'b0);
    chk("r34_rst_valid", mem_req_valid, 1'b0);
    @(posedge clock); #1; reset = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
    @(negedge clock);
    chk("r34_late_load", load_data_memory, 32'h0);
    chk("r34_late_stall", stall_memory, 1'b0);
    chk("r34_late_opwrite", opwrite_memory, 1'b0);
    chk("r34_late_valid", mem_req_valid, 1'b0);
    @(posedge clock); #1; mem_resp_valid = 1'b0;

    // Reset while a store waits for ready.
    ALU_result_execute = 32'h20; store_data_execute = 32'h77; memWrite_execute = 1'b1;
    funct3_execute = 3'b010; opwrite_execute = 1'b1;
    @(posedge clock); #1; idle_inputs();
    @(negedge clock);
    chk("rq_valid", mem_req_valid, 1'b1);
    @(posedge clock); #1; reset = 1'b1;
    @(negedge clock);
    chk("rq_rst_valid", mem_req_valid, 1'b0);
    @(posedge clock); #1; reset = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    chk("rq_after_valid", mem_req_valid, 1'b0);
    chk("rq_after_stall", stall_memory, 1'b0);
    @(posedge clock); #1; mem_req_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, datapath width; ADDRESS_BITS, default 20, word-address width.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 ALU_result_execute  in  DATA_WIDTH  byte address or ALU result.
REQ-005 store_data_execute  in  DATA_WIDTH  store data.
REQ-006 memRead_execute, memWrite_execute  in  1 each  load / store request.
REQ-007 funct3_execute  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 opwrite_execute, opsel_execute  in  1 each; opReg_execute  in  5  writeback controls, passed through.
REQ-009 mem_req_valid  out  1; mem_req_ready  in  1; mem_req_write  out  1; mem_req_addr  out  ADDRESS_BITS; mem_req_wdata  out  DATA_WIDTH; mem_req_byte_en  out  4.
REQ-010 mem_resp_valid  in  1; mem_resp_data  in  DATA_WIDTH  load response word.
REQ-011 ALU_result_memory, load_data_memory  out  DATA_WIDTH; opwrite_memory, opsel_memory  out  1; opReg_memory  out  5  feed to memory/writeback pipe register.
REQ-012 stall_memory  out  1  upstream hold; misaligned_memory  out  1  one-cycle misalignment pulse.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT.
REQ-014 IDLE, no memRead/memWrite: execute inputs SHALL pass combinationally to *_memory outputs, load_data_memory = 0, stall_memory = 0 (zero latency).
REQ-015 IDLE, memRead or memWrite, aligned: SHALL capture address, store data, funct3, read/write, opwrite, opsel, opReg; stall_memory = 1; opwrite_memory = 0 (bubble); next state REQ.
REQ-016 Alignment: H/HU SHALL require addr[0]=0; W SHALL require addr[1:0]=00; misaligned op SHALL pulse misaligned_memory for one cycle, issue no request, stay IDLE, output a bubble (opwrite_memory = 0), stall_memory = 0.
REQ-017 REQ: mem_req_valid = 1; mem_req_addr = captured addr[ADDRESS_BITS+1:2]; mem_req_write = captured write; all request outputs SHALL stay stable until mem_req_ready.
REQ-018 Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111; loads SHALL drive same enables.
REQ-019 Store wdata SHALL replicate low byte (B) or halfword (H) across the word; W unchanged.
REQ-020 REQ with mem_req_ready, store: operation complete that cycle; stall_memory = 0; captured controls on outputs; next IDLE.
REQ-021 REQ with mem_req_ready, load: stall_memory = 1, bubble outputs; next WAIT.
REQ-022 WAIT: mem_resp_valid SHALL be honoured only in WAIT; on it, load_data_memory = aligned/extended data, captured controls output, stall_memory = 0, next IDLE; otherwise stall_memory = 1, bubble.
REQ-023 Load extraction: byte/halfword selected by captured addr[1:0]; B/H sign-extend, BU/HU zero-extend, W as-is.
REQ-024 ALU_result_memory SHALL equal captured address on completing memory ops.
REQ-025 At most one outstanding request; mem_req_valid SHALL be 0 outside REQ.
REQ-026 memRead and memWrite both high SHALL be treated as store.

Reset
REQ-027 reset SHALL force IDLE next edge, clear all captured registers; during and after reset cycle mem_req_valid = 0, stall_memory = 0, misaligned_memory = 0, opwrite_memory follows IDLE pass-through of reset-time inputs masked to 0 while reset high.
REQ-028 Reset mid-operation (REQ or WAIT) SHALL abandon the op; a late mem_resp_valid arriving in IDLE SHALL be ignored.

Verification
REQ-029 ALU op addr 0x40, opwrite=1, opReg=5 in IDLE -> same cycle outputs ALU_result_memory=0x40, opwrite_memory=1, stall_memory=0, mem_req_valid=0.
REQ-030 SW addr 0x104, data 0xDEADBEEF, ready held 1 -> cycle1 stall=1; cycle2 mem_req_valid=1, addr=0x41, byte_en=1111, wdata=0xDEADBEEF, stall=0; total 2 cycles.
REQ-031 LB addr 0x203, resp 0x80FF_0000 one cycle after handshake -> load_data_memory=0xFFFFFF80; LBU same -> 0x00000080; 3-cycle latency.
REQ-032 SH addr 0x102 with mem_req_ready low 4 cycles -> request fields stable, stall=1 throughout, byte_en=1100, wdata=0xBEEFBEEF for data 0xBEEF; completes on ready.
REQ-033 LW addr 0x101 -> misaligned_memory=1 one cycle, mem_req_valid stays 0, opwrite_memory=0.
REQ-034 LW in WAIT, assert reset, then mem_resp_valid in IDLE -> state IDLE, stall=0, no load data forwarded, opwrite_memory=0.
